// File: rtl/fpc_pkg.sv
// Shared constants and width helpers for the frame position counter.
package fpc_pkg;

    // Default frame geometry and multiframe counter width
    localparam int FPC_ROW_N   = 4;
    localparam int FPC_COL_N   = 1041;
    localparam int FPC_OH_COLS = 16;
    localparam int FPC_MF_W    = 8;

    // Bits needed to hold values 0..n-1, never less than one bit
    function automatic int fpc_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Terminal count of a free-running counter of width w
    function automatic int fpc_mf_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

// File: rtl/wrap_cnt.sv
// Wrapping up-counter: counts 0..MAX on en, clears on clr, flags the last value.
// Any value above MAX (not reachable in normal operation) returns to 0 on the next en.
module wrap_cnt
    import fpc_pkg::*;
#(
    parameter int MAX = 1,
    parameter int W   = fpc_w(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    localparam logic [W-1:0] TOP = W'(MAX);

    // Count register: clear beats enable, wrap to 0 at or above the terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt >= TOP) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign at_max = (cnt == TOP);

endmodule

// File: rtl/fpc_mf.sv
// Frame position counter: tracks column, row and multiframe index of a
// row/column framed stream. Overhead columns at the start of each row and the
// last column of each row advance on their own; payload columns wait for i_valid.
module fpc_mf
    import fpc_pkg::*;
#(
    parameter int ROW_N   = FPC_ROW_N,
    parameter int COL_N   = FPC_COL_N,
    parameter int OH_COLS = FPC_OH_COLS,
    parameter int MF_W    = FPC_MF_W,
    parameter int ROW_W   = fpc_w(ROW_N),
    parameter int COL_W   = fpc_w(COL_N)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic             i_line_retrans_req,
    input  logic             i_resync,
    output logic [ROW_W-1:0] o_row_cnt,
    output logic [COL_W-1:0] o_col_cnt,
    output logic [MF_W-1:0]  o_mf_cnt,
    output logic             o_sof,
    output logic             o_eol,
    output logic             o_eof,
    output logic             o_in_oh,
    output logic             o_adv
);

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [MF_W-1:0]  mf;

    logic col_last;
    logic row_last;
    logic mf_last;
    logic in_oh;
    logic adv;
    logic row_en;
    logic mf_en;

    // Overhead decode; with no overhead columns the compare is dropped entirely
    generate
        if (OH_COLS > 0) begin : g_oh
            assign in_oh = (col < COL_W'(OH_COLS));
        end else begin : g_no_oh
            assign in_oh = 1'b0;
        end
    endgenerate

    // Advance decision: resync and hold both block it; otherwise overhead and
    // last column self-advance, payload columns need a valid beat
    always_comb begin
        adv = 1'b0;
        if (!i_resync && !i_line_retrans_req) begin
            adv = i_valid || in_oh || col_last;
        end
    end

    // Carry chain: row steps on column wrap, multiframe steps on row wrap
    always_comb begin
        row_en = adv && col_last;
        mf_en  = row_en && row_last;
    end

    wrap_cnt #(
        .MAX (COL_N - 1),
        .W   (COL_W)
    ) u_col (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .en     (adv),
        .clr    (i_resync),
        .cnt    (col),
        .at_max (col_last)
    );

    wrap_cnt #(
        .MAX (ROW_N - 1),
        .W   (ROW_W)
    ) u_row (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .en     (row_en),
        .clr    (i_resync),
        .cnt    (row),
        .at_max (row_last)
    );

    wrap_cnt #(
        .MAX (fpc_mf_max(MF_W)),
        .W   (MF_W)
    ) u_mf (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .en     (mf_en),
        .clr    (i_resync),
        .cnt    (mf),
        .at_max (mf_last)
    );

    // Position flags decoded from the registered counters
    always_comb begin
        o_sof   = (row == '0) && (col == '0);
        o_eol   = col_last;
        o_eof   = col_last && row_last;
        o_in_oh = in_oh;
        o_adv   = adv;
    end

    assign o_row_cnt = row;
    assign o_col_cnt = col;
    assign o_mf_cnt  = mf;

    // The multiframe wrap flag is not needed by anything downstream
    logic unused_mf_last;
    assign unused_mf_last = mf_last;

endmodule

// File: tb/tb_fpc_mf.sv
// Directed bench for fpc_mf: default geometry, a short frame with a 2-bit
// multiframe counter, and a short frame with no overhead columns.
module tb_fpc_mf;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- default-parameter instance
    logic        rst_a = 1'b0, valid_a = 1'b0, retx_a = 1'b0, resync_a = 1'b0;
    logic [1:0]  row_a;
    logic [10:0] col_a;
    logic [7:0]  mf_a;
    logic        sof_a, eol_a, eof_a, oh_a, adv_a;

    fpc_mf dut_a (
        .i_clk              (clk),
        .i_rst_n            (rst_a),
        .i_valid            (valid_a),
        .i_line_retrans_req (retx_a),
        .i_resync           (resync_a),
        .o_row_cnt          (row_a),
        .o_col_cnt          (col_a),
        .o_mf_cnt           (mf_a),
        .o_sof              (sof_a),
        .o_eol              (eol_a),
        .o_eof              (eof_a),
        .o_in_oh            (oh_a),
        .o_adv              (adv_a)
    );

    // ---------------- short frame, 2-bit multiframe
    logic        rst_b = 1'b0, valid_b = 1'b0, retx_b = 1'b0, resync_b = 1'b0;
    logic        row_b;
    logic [2:0]  col_b;
    logic [1:0]  mf_b;
    logic        sof_b, eol_b, eof_b, oh_b, adv_b;

    fpc_mf #(.ROW_N(2), .COL_N(8), .OH_COLS(2), .MF_W(2)) dut_b (
        .i_clk              (clk),
        .i_rst_n            (rst_b),
        .i_valid            (valid_b),
        .i_line_retrans_req (retx_b),
        .i_resync           (resync_b),
        .o_row_cnt          (row_b),
        .o_col_cnt          (col_b),
        .o_mf_cnt           (mf_b),
        .o_sof              (sof_b),
        .o_eol              (eol_b),
        .o_eof              (eof_b),
        .o_in_oh            (oh_b),
        .o_adv              (adv_b)
    );

    // ---------------- short frame, no overhead
    logic        rst_c = 1'b0, valid_c = 1'b0, retx_c = 1'b0, resync_c = 1'b0;
    logic        row_c;
    logic [2:0]  col_c;
    logic [7:0]  mf_c;
    logic        sof_c, eol_c, eof_c, oh_c, adv_c;

    fpc_mf #(.ROW_N(2), .COL_N(8), .OH_COLS(0)) dut_c (
        .i_clk              (clk),
        .i_rst_n            (rst_c),
        .i_valid            (valid_c),
        .i_line_retrans_req (retx_c),
        .i_resync           (resync_c),
        .o_row_cnt          (row_c),
        .o_col_cnt          (col_c),
        .o_mf_cnt           (mf_c),
        .o_sof              (sof_c),
        .o_eol              (eol_c),
        .o_eof              (eof_c),
        .o_in_oh            (oh_c),
        .o_adv              (adv_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: return 1 ns after the rising edge so outputs are settled
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // ======== default instance: reset values
        #23;
        check("a_rst_row", row_a, 0);
        check("a_rst_col", col_a, 0);
        check("a_rst_mf",  mf_a,  0);
        check("a_rst_sof", sof_a, 1);
        check("a_rst_oh",  oh_a,  1);
        check("a_rst_eol", eol_a, 0);
        check("a_rst_eof", eof_a, 0);

        // release away from the edge, stream valid beats
        @(posedge clk); #1;
        rst_a   = 1'b1;
        valid_a = 1'b1;
        tick(1);
        check("a_col1", col_a, 1);
        check("a_sof_gone", sof_a, 0);
        tick(1039);
        check("a_col1040", col_a, 1040);
        check("a_eol", eol_a, 1);
        check("a_eof_row0", eof_a, 0);
        tick(1);
        check("a_row1", row_a, 1);
        check("a_row1_col", col_a, 0);

        // run to last position of the frame: 3*1041+1040 advances in total
        tick(3122);
        check("a_last_row", row_a, 3);
        check("a_last_col", col_a, 1040);
        check("a_eof", eof_a, 1);

        // hold at the last position for 5 cycles
        retx_a = 1'b1;
        #1;
        check("a_hold_adv", adv_a, 0);
        tick(5);
        check("a_hold_row", row_a, 3);
        check("a_hold_col", col_a, 1040);
        check("a_hold_mf",  mf_a,  0);
        retx_a = 1'b0;
        #1;
        check("a_last_adv", adv_a, 1);
        tick(1);
        check("a_wrap_row", row_a, 0);
        check("a_wrap_col", col_a, 0);
        check("a_wrap_mf",  mf_a,  1);
        check("a_wrap_sof", sof_a, 1);

        // go to (2,500) then resync while holding
        tick(2*1041 + 500);
        check("a_pos_row", row_a, 2);
        check("a_pos_col", col_a, 500);
        check("a_pos_mf",  mf_a,  1);
        resync_a = 1'b1;
        retx_a   = 1'b1;
        #1;
        check("a_resync_adv", adv_a, 0);
        tick(1);
        resync_a = 1'b0;
        retx_a   = 1'b0;
        check("a_resync_row", row_a, 0);
        check("a_resync_col", col_a, 0);
        check("a_resync_mf",  mf_a,  0);
        check("a_resync_sof", sof_a, 1);

        // mid-frame reset, then no valid: overhead columns only
        tick(700);
        valid_a = 1'b0;
        #2;
        rst_a = 1'b0;
        #1;
        check("a_mid_rst_col", col_a, 0);
        @(posedge clk); #1;
        rst_a = 1'b1;
        tick(15);
        check("a_oh_col15", col_a, 15);
        check("a_oh_in15", oh_a, 1);
        tick(1);
        check("a_oh_col16", col_a, 16);
        check("a_oh_in16", oh_a, 0);
        check("a_stall_adv", adv_a, 0);
        tick(4);
        check("a_stall_col", col_a, 16);
        check("a_stall_row", row_a, 0);

        // ======== 2-bit multiframe, 16-cycle frames
        rst_b   = 1'b1;
        valid_b = 1'b1;
        check("b_mf0", mf_b, 0);
        tick(16);
        check("b_mf1", mf_b, 1);
        tick(16);
        check("b_mf2", mf_b, 2);
        tick(16);
        check("b_mf3", mf_b, 3);
        tick(16);
        check("b_mf_wrap", mf_b, 0);
        check("b_sof", sof_b, 1);
        tick(5);
        check("b_mid_col", col_b, 5);
        tick(9);
        check("b_mid_row", row_b, 1);
        tick(3);
        check("b_mf_again", mf_b, 1);
        #2;
        rst_b = 1'b0;
        #1;
        check("b_async_row", row_b, 0);
        check("b_async_col", col_b, 0);
        check("b_async_mf",  mf_b,  0);
        check("b_async_sof", sof_b, 1);

        // ======== no overhead columns
        @(posedge clk); #1;
        rst_c = 1'b1;
        #1;
        check("c_idle_adv", adv_c, 0);
        check("c_idle_oh", oh_c, 0);
        tick(2);
        check("c_idle_col", col_c, 0);
        valid_c = 1'b1;
        tick(7);
        check("c_col7", col_c, 7);
        valid_c = 1'b0;
        #1;
        check("c_last_adv", adv_c, 1);
        tick(1);
        check("c_wrap_row", row_c, 1);
        check("c_wrap_col", col_c, 0);
        check("c_wrap_adv", adv_c, 0);
        tick(3);
        check("c_stall_row", row_c, 1);
        check("c_stall_col", col_c, 0);
        check("c_mf", mf_c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Bound the whole run
    initial begin
        #500000;
        $display("FAIL timeout: got %0d, expected %0d", 0, 1);
        $fatal(1, "timeout");
    end

endmodule
